// File: rtl/gmii_fcs_checker.sv
// GMII receive FCS checker with a 4-cycle pass-through pipeline.
// Latency: data/valid/error out = 4 cycles; frame_done pulses 1 cycle after rx_dv falls; counters follow 1 cycle after frame_done.
// Backpressure: none, streaming GMII with no stall path; every frame is checked at line rate.
//
// Ports:
//   aclk, areset                       clock, asynchronous active-high reset
//   gmii_rxd/_rx_dv/_rx_er             receive byte stream (preamble + SFD + frame + FCS)
//   gmii_rxd_out/_rx_dv_out/_rx_er_out stream delayed by 4 cycles
//   frame_done, frame_good, frame_len  end-of-frame pulse with verdict and byte count after the SFD
//   good_frames, bad_frames, cnt_clear saturating 32-bit frame counters with synchronous clear
//
// Build option: define GMII_FCS_STRIP_EN to drop the 4 FCS bytes from the delayed stream
// by gating the delayed valid/error with the live rx_dv. Checking and counters are unaffected.
module gmii_fcs_checker #(
    parameter int MIN_FRAME_LEN = 64
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  gmii_rxd_out,
    output logic        gmii_rx_dv_out,
    output logic        gmii_rx_er_out,
    output logic        frame_done,
    output logic        frame_good,
    output logic [15:0] frame_len,
    output logic [31:0] good_frames,
    output logic [31:0] bad_frames,
    input  logic        cnt_clear
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    // Register value left behind after a frame plus its own correct FCS has been
    // shifted through, in the MSB-first register orientation used below.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_sfd;
    logic        w_end;
    logic        r_armed;
    logic [31:0] r_crc;
    logic [15:0] r_len;
    logic        r_err;
    logic        r_frame_done;
    logic        r_frame_good;
    logic [15:0] r_frame_len;
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;
    logic [7:0]  r_rxd_pipe [4];
    logic [3:0]  r_dv_pipe;
    logic [3:0]  r_er_pipe;

    // Non-reflected register fed with data bits LSB first: equivalent to the usual
    // reflected Ethernet CRC, only stored bit-reversed.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        logic        fb;
        v = c;
        for (int i = 0; i < 8; i++) begin
            fb = v[31] ^ d[i];
            v  = {v[30:0], 1'b0};
            if (fb) v = v ^ 32'h04C11DB7;
        end
        return v;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            // Until dv=0 has been seen since reset we may be mid-frame, so refuse to sync.
            IDLE: if (gmii_rx_dv)
                      w_state_nxt = (r_armed && gmii_rxd == 8'h55) ? PREAMBLE : DROP;
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else if (gmii_rxd == 8'hD5) begin
                    w_state_nxt = DATA;
                    w_sfd       = 1'b1;
                end else if (gmii_rxd != 8'h55) begin
                    w_state_nxt = DROP;
                end
            end
            DATA: if (!gmii_rx_dv) begin
                      w_state_nxt = IDLE;
                      w_end       = 1'b1;
                  end
            DROP: if (!gmii_rx_dv) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!gmii_rx_dv) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_crc <= 32'hFFFFFFFF;
            r_len <= 16'd0;
            r_err <= 1'b0;
        end else if (w_sfd) begin
            r_crc <= 32'hFFFFFFFF;
            r_len <= 16'd0;
            r_err <= 1'b0;
        end else if (r_state == DATA && gmii_rx_dv) begin
            r_crc <= crc_byte(r_crc, gmii_rxd);
            if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
            if (gmii_rx_er) r_err <= 1'b1;
        end
    end

    // Verdict and length are captured once per frame and held until the next one.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_frame_done <= 1'b0;
            r_frame_good <= 1'b0;
            r_frame_len  <= 16'd0;
        end else begin
            r_frame_done <= w_end;
            if (w_end) begin
                r_frame_len  <= r_len;
                r_frame_good <= (r_crc == CRC_RESIDUE) && (r_len >= MIN_LEN) && !r_err;
            end
        end
    end

    // Counting on the pulse makes a clear during the frame_done cycle coincide with the increment.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_good_cnt <= 32'd0;
            r_bad_cnt  <= 32'd0;
        end else if (cnt_clear) begin
            r_good_cnt <= 32'd0;
            r_bad_cnt  <= 32'd0;
        end else if (r_frame_done) begin
            if (r_frame_good) begin
                if (r_good_cnt != 32'hFFFFFFFF) r_good_cnt <= r_good_cnt + 32'd1;
            end else begin
                if (r_bad_cnt != 32'hFFFFFFFF) r_bad_cnt <= r_bad_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 4; i++) r_rxd_pipe[i] <= 8'd0;
            r_dv_pipe <= 4'd0;
            r_er_pipe <= 4'd0;
        end else begin
            r_rxd_pipe[0] <= gmii_rxd;
            for (int i = 1; i < 4; i++) r_rxd_pipe[i] <= r_rxd_pipe[i-1];
            r_dv_pipe <= {r_dv_pipe[2:0], gmii_rx_dv};
            r_er_pipe <= {r_er_pipe[2:0], gmii_rx_er};
        end
    end

    assign gmii_rxd_out = r_rxd_pipe[3];
`ifdef GMII_FCS_STRIP_EN
    // The live dv drops 4 cycles before the delayed one, exactly covering the FCS bytes.
    assign gmii_rx_dv_out = r_dv_pipe[3] & gmii_rx_dv;
    assign gmii_rx_er_out = r_er_pipe[3] & gmii_rx_dv;
`else
    assign gmii_rx_dv_out = r_dv_pipe[3];
    assign gmii_rx_er_out = r_er_pipe[3];
`endif

    assign frame_done  = r_frame_done;
    assign frame_good  = r_frame_good;
    assign frame_len   = r_frame_len;
    assign good_frames = r_good_cnt;
    assign bad_frames  = r_bad_cnt;

endmodule
